// File: rtl/mempool_tile_resp_arb_pkg.sv
// Shared helpers for the MemPool tile response age arbiter.
// Index and age types depend on per-instance parameters, so the modules derive
// their own idx/age widths through idx_width() and the module parameters.
package mempool_tile_resp_arb_pkg;

    // Offset that pushes indices below rr_ptr behind every index at/after it
    localparam int RotOffset = 32'h0001_0000;

    function automatic int idx_width(input int num);
        return (num > 1) ? $clog2(num) : 1;
    endfunction

    // True when request a beats request b: older age first, then the index
    // nearest at/after rr_ptr going circularly upward.
    function automatic logic age_higher(input int a_age, input int a_idx,
                                        input int b_age, input int b_idx,
                                        input int rr_ptr);
        int a_pos;
        int b_pos;
        if (a_age != b_age) begin
            return a_age > b_age;
        end
        a_pos = (a_idx >= rr_ptr) ? (a_idx - rr_ptr) : (a_idx + RotOffset - rr_ptr);
        b_pos = (b_idx >= rr_ptr) ? (b_idx - rr_ptr) : (b_idx + RotOffset - rr_ptr);
        return a_pos < b_pos;
    endfunction

endpackage

// File: rtl/mempool_tile_resp_age_sel.sv
// Combinational output assignment for the tile response age arbiter.
// Locked outputs keep their input; free outputs take the remaining eligible
// inputs in priority order, lowest output index first.
module mempool_tile_resp_age_sel
    import mempool_tile_resp_arb_pkg::*;
#(
    parameter int NumInp   = 16,
    parameter int NumOut   = 3,
    parameter int AgeWidth = 4,
    localparam int IdxW    = idx_width(NumInp)
) (
    input  logic [NumInp-1:0][AgeWidth-1:0] age_i,
    input  logic [NumInp-1:0]               elig_i,
    input  logic [IdxW-1:0]                 rr_ptr_i,
    input  logic [NumOut-1:0]               lock_i,
    input  logic [NumOut-1:0][IdxW-1:0]     lock_idx_i,
    output logic [NumOut-1:0][IdxW-1:0]     sel_idx_o,
    output logic [NumOut-1:0]               sel_vld_o
);

    // Walk outputs in order, each free one grabbing the best input still available
    always_comb begin
        logic [NumInp-1:0] avail;
        logic              found;
        logic [IdxW-1:0]   best;
        avail     = elig_i;
        found     = 1'b0;
        best      = '0;
        sel_idx_o = '0;
        sel_vld_o = '0;
        for (int k = 0; k < NumOut; k++) begin
            if (lock_i[k]) begin
                sel_idx_o[k] = lock_idx_i[k];
                sel_vld_o[k] = 1'b1;
            end else begin
                found = 1'b0;
                best  = '0;
                for (int i = 0; i < NumInp; i++) begin
                    if (avail[i] && (!found ||
                        age_higher(32'(age_i[i]), i, 32'(age_i[best]), 32'(best),
                                   32'(rr_ptr_i)))) begin
                        found = 1'b1;
                        best  = IdxW'(i);
                    end
                end
                if (found) begin
                    sel_idx_o[k] = best;
                    sel_vld_o[k] = 1'b1;
                    avail[best]  = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/mempool_tile_resp_age_arbiter.sv
// N-to-M tile response arbiter with per-input saturating age counters.
// Oldest pending input wins, ties go round-robin from rr_ptr; a granted output
// stays locked to its input until the handshake so data_o/valid_o hold steady.
// Optional build macro MEMPOOL_RESP_ARB_OUT_REG_EN adds a pipeline register on
// every output (1-cycle latency, full throughput).
module mempool_tile_resp_age_arbiter
    import mempool_tile_resp_arb_pkg::*;
#(
    parameter int  NumInp    = 16,
    parameter int  NumOut    = 3,
    parameter int  AgeWidth  = 4,
    parameter type payload_t = logic
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  payload_t [NumInp-1:0]   data_i,
    input  logic [NumInp-1:0]       valid_i,
    output logic [NumInp-1:0]       ready_o,
    output payload_t [NumOut-1:0]   data_o,
    output logic [NumOut-1:0]       valid_o,
    input  logic [NumOut-1:0]       ready_i,
    output logic [NumInp-1:0]       starve_o
);

    localparam int IdxW = idx_width(NumInp);
    localparam logic [AgeWidth-1:0] AgeMax = '1;

    logic [NumInp-1:0][AgeWidth-1:0] age_q, age_d;
    logic [NumOut-1:0]               lock_q, lock_d;
    logic [NumOut-1:0][IdxW-1:0]     lock_idx_q, lock_idx_d;
    logic [IdxW-1:0]                 rr_ptr_q, rr_ptr_d;
    logic [NumOut-1:0]               lock_act;
    logic [NumOut-1:0]               sel_vld;
    logic [NumOut-1:0][IdxW-1:0]     sel_idx;
    logic [NumOut-1:0]               accept;
    logic [NumInp-1:0]               elig;
    logic [NumInp-1:0]               hs_in;

    // A lock only counts while its input is still valid; locked inputs leave the pool
    always_comb begin
        lock_act = '0;
        elig     = valid_i;
        for (int k = 0; k < NumOut; k++) begin
            lock_act[k] = lock_q[k] & valid_i[lock_idx_q[k]];
            if (lock_act[k]) begin
                elig[lock_idx_q[k]] = 1'b0;
            end
        end
    end

    mempool_tile_resp_age_sel #(
        .NumInp   (NumInp),
        .NumOut   (NumOut),
        .AgeWidth (AgeWidth)
    ) i_sel (
        .age_i      (age_q),
        .elig_i     (elig),
        .rr_ptr_i   (rr_ptr_q),
        .lock_i     (lock_act),
        .lock_idx_i (lock_idx_q),
        .sel_idx_o  (sel_idx),
        .sel_vld_o  (sel_vld)
    );

`ifdef MEMPOOL_RESP_ARB_OUT_REG_EN
    logic [NumOut-1:0]     out_vld_q, out_vld_d;
    payload_t [NumOut-1:0] out_data_q, out_data_d;

    // Register slot takes a new beat when empty or draining this cycle
    always_comb begin
        accept     = ~out_vld_q | ready_i;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        for (int k = 0; k < NumOut; k++) begin
            if (accept[k]) begin
                out_vld_d[k]  = sel_vld[k];
                out_data_d[k] = data_i[sel_idx[k]];
            end
        end
        valid_o = out_vld_q;
        data_o  = out_data_q;
    end

    // Output valid flags are control state and clear on reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_vld_q <= '0;
        end else begin
            out_vld_q <= out_vld_d;
        end
    end

    // Output payload is only meaningful under out_vld_q, so it needs no reset
    always_ff @(posedge clk_i) begin
        out_data_q <= out_data_d;
    end
`else
    // Combinational path: the selected input goes straight to the output
    always_comb begin
        accept  = ready_i;
        valid_o = sel_vld;
        for (int k = 0; k < NumOut; k++) begin
            data_o[k] = data_i[sel_idx[k]];
        end
    end
`endif

    // Handshakes, age update, round-robin pointer and lock capture
    always_comb begin
        ready_o = '0;
        for (int k = 0; k < NumOut; k++) begin
            if (sel_vld[k] && accept[k]) begin
                ready_o[sel_idx[k]] = 1'b1;
            end
        end
        hs_in    = valid_i & ready_o;
        age_d    = age_q;
        rr_ptr_d = rr_ptr_q;
        for (int i = 0; i < NumInp; i++) begin
            if (!valid_i[i] || hs_in[i]) begin
                age_d[i] = '0;
            end else if (age_q[i] != AgeMax) begin
                age_d[i] = age_q[i] + 1'b1;
            end
            if (hs_in[i]) begin
                rr_ptr_d = (i == NumInp - 1) ? '0 : IdxW'(i + 1);
            end
        end
        lock_d     = sel_vld & ~accept;
        lock_idx_d = sel_idx;
        starve_o   = '0;
        for (int i = 0; i < NumInp; i++) begin
            starve_o[i] = valid_i[i] & (age_q[i] == AgeMax);
        end
    end

    // Arbitration state; reset drops any in-flight lock immediately
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            age_q      <= '0;
            lock_q     <= '0;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            age_q      <= age_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

`ifndef SYNTHESIS
    // Requesters must hold valid_i until their locked output completes
    for (genvar k = 0; k < NumOut; k++) begin : g_lock_chk
        a_hold_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
            lock_q[k] |-> valid_i[lock_idx_q[k]]);
    end
`endif

endmodule

// File: tb/tb_mempool_tile_resp_age_arbiter.sv
// Directed scoreboard bench for the tile response age arbiter (4 in, 2 out).
module tb_mempool_tile_resp_age_arbiter;

    localparam int NI = 4;
    localparam int NO = 2;
    localparam int AW = 3;

    logic                clk_i;
    logic                rst_ni;
    logic [NI-1:0][7:0]  data_i;
    logic [NI-1:0]       valid_i;
    logic [NI-1:0]       ready_o;
    logic [NO-1:0][7:0]  data_o;
    logic [NO-1:0]       valid_o;
    logic [NO-1:0]       ready_i;
    logic [NI-1:0]       starve_o;

    typedef struct {
        string      tag;
        logic [1:0] vo;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [3:0] ro;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    mempool_tile_resp_age_arbiter #(
        .NumInp    (NI),
        .NumOut    (NO),
        .AgeWidth  (AW),
        .payload_t (logic [7:0])
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .data_i   (data_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .starve_o (starve_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_sb();
        exp_t e;
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk({e.tag, "_valid_o"}, 32'(valid_o), 32'(e.vo));
        chk({e.tag, "_ready_o"}, 32'(ready_o), 32'(e.ro));
        if (e.vo[0]) chk({e.tag, "_data_o0"}, 32'(data_o[0]), 32'(e.d0));
        if (e.vo[1]) chk({e.tag, "_data_o1"}, 32'(data_o[1]), 32'(e.d1));
    endtask

    // Drive one cycle of stimulus, queue its expected response, check at negedge
    task automatic step(input string tag, input logic [3:0] vi, input logic [1:0] ri,
                        input logic [1:0] vo, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [3:0] ro);
        exp_t e;
        valid_i = vi;
        ready_i = ri;
        e.tag = tag; e.vo = vo; e.d0 = d0; e.d1 = d1; e.ro = ro;
        sb.push_back(e);
        @(negedge clk_i);
        check_sb();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NI; i++) data_i[i] = 8'hA0 + 8'(i);
        rst_ni  = 1'b0;
        valid_i = '0;
        ready_i = '0;
        #3;
        chk("rst_valid_o", 32'(valid_o), 32'd0);
        chk("rst_ready_o", 32'(ready_o), 32'd0);
        chk("rst_starve_o", 32'(starve_o), 32'd0);
        chk("rst_rr", 32'(dut.rr_ptr_q), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // 1: all valid, both outputs ready: grants rotate {0,1},{2,3},{0,1}
        step("t1a", 4'b1111, 2'b11, 2'b11, 8'hA0, 8'hA1, 4'b0011);
        step("t1b", 4'b1111, 2'b11, 2'b11, 8'hA2, 8'hA3, 4'b1100);
        step("t1c", 4'b1111, 2'b11, 2'b11, 8'hA0, 8'hA1, 4'b0011);
        chk("t1_rr", 32'(dut.rr_ptr_q), 32'd2);
        step("clr1", 4'b0000, 2'b11, 2'b00, 8'h00, 8'h00, 4'b0000);

        // 2: single request stalled five cycles stays stable, then completes
        for (int j = 0; j < 5; j++)
            step("t2hold", 4'b0001, 2'b00, 2'b01, 8'hA0, 8'h00, 4'b0000);
        chk("t2_age0", 32'(dut.age_q[0]), 32'd5);
        step("t2rel", 4'b0001, 2'b01, 2'b01, 8'hA0, 8'h00, 4'b0001);
        chk("t2_rr", 32'(dut.rr_ptr_q), 32'd1);
        step("clr2", 4'b0000, 2'b11, 2'b00, 8'h00, 8'h00, 4'b0000);

        // 3: input 3 blocked behind two locked outputs saturates at 7
        for (int j = 0; j < 6; j++)
            step("t3", 4'b1110, 2'b00, 2'b11, 8'hA1, 8'hA2, 4'b0000);
        chk("t3_age3_6", 32'(dut.age_q[3]), 32'd6);
        chk("t3_nostarve", 32'(starve_o), 32'd0);
        step("t3", 4'b1110, 2'b00, 2'b11, 8'hA1, 8'hA2, 4'b0000);
        chk("t3_starve", 32'(starve_o), 32'b1110);
        step("t3", 4'b1110, 2'b00, 2'b11, 8'hA1, 8'hA2, 4'b0000);
        step("t3", 4'b1110, 2'b00, 2'b11, 8'hA1, 8'hA2, 4'b0000);
        chk("t3_age3_sat", 32'(dut.age_q[3]), 32'd7);
        chk("t3_starve_hold", 32'(starve_o), 32'b1110);
        step("t3rel", 4'b1110, 2'b11, 2'b11, 8'hA1, 8'hA2, 4'b0110);
        step("t4pre", 4'b1000, 2'b11, 2'b01, 8'hA3, 8'h00, 4'b1000);
        step("clr3", 4'b0000, 2'b11, 2'b00, 8'h00, 8'h00, 4'b0000);

        // 4: older input 2 beats input 0 even though rr_ptr points at 0
        step("t4c0", 4'b1000, 2'b00, 2'b01, 8'hA3, 8'h00, 4'b0000);
        step("t4c1", 4'b1110, 2'b00, 2'b11, 8'hA3, 8'hA1, 4'b0000);
        step("t4c2", 4'b1110, 2'b00, 2'b11, 8'hA3, 8'hA1, 4'b0000);
        step("t4c3", 4'b1111, 2'b00, 2'b11, 8'hA3, 8'hA1, 4'b0000);
        chk("t4_age2", 32'(dut.age_q[2]), 32'd3);
        chk("t4_age0", 32'(dut.age_q[0]), 32'd1);
        chk("t4_rr", 32'(dut.rr_ptr_q), 32'd0);
        step("t4c4", 4'b1111, 2'b01, 2'b11, 8'hA3, 8'hA1, 4'b1000);
        chk("t4_rr_after", 32'(dut.rr_ptr_q), 32'd0);
        step("t4c5", 4'b0111, 2'b01, 2'b11, 8'hA2, 8'hA1, 4'b0100);
        step("t4c6", 4'b0011, 2'b11, 2'b11, 8'hA0, 8'hA1, 4'b0011);
        step("clr4", 4'b0000, 2'b11, 2'b00, 8'h00, 8'h00, 4'b0000);

        // 5: output 0 locked on the oldest input; output 1 must take another
        step("t5d0", 4'b0010, 2'b00, 2'b01, 8'hA1, 8'h00, 4'b0000);
        step("t5d1", 4'b0010, 2'b00, 2'b01, 8'hA1, 8'h00, 4'b0000);
        step("t5d2", 4'b1011, 2'b00, 2'b11, 8'hA1, 8'hA3, 4'b0000);
        step("t5d3", 4'b1011, 2'b10, 2'b11, 8'hA1, 8'hA3, 4'b1000);
        step("t5d4", 4'b0011, 2'b11, 2'b11, 8'hA1, 8'hA0, 4'b0011);
        step("clr5", 4'b0000, 2'b11, 2'b00, 8'h00, 8'h00, 4'b0000);

        // 6: asynchronous reset in the middle of a stalled burst
        step("t6a", 4'b1111, 2'b00, 2'b11, 8'hA2, 8'hA3, 4'b0000);
        step("t6b", 4'b1111, 2'b00, 2'b11, 8'hA2, 8'hA3, 4'b0000);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("t6_age2", 32'(dut.age_q[2]), 32'd0);
        chk("t6_lock", 32'(dut.lock_q), 32'd0);
        chk("t6_rr", 32'(dut.rr_ptr_q), 32'd0);
        chk("t6_data_o0", 32'(data_o[0]), 32'hA0);
        valid_i = '0;
        #1;
        chk("t6_valid_o", 32'(valid_o), 32'd0);
        chk("t6_ready_o", 32'(ready_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        step("t6post", 4'b0001, 2'b11, 2'b01, 8'hA0, 8'h00, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
